iiitb_dmem_arbiter: RTL
=======================

Name: iiitb_dmem_arbiter

Overview:
- Shares the single-port 32x32 data memory between the rv32i pipeline MEM stage and a host/loader port (testbench, debug or program preload).
- The pipeline has priority. The host is guaranteed service within MAX_WAIT cycles.
- The memory has 1-cycle synchronous read latency. The arbiter issues at most one access per cycle and routes the returned read data to the correct requester.

Parameters:
- AW, 5, memory address width (32 words).
- MAX_WAIT, 4, consecutive cycles a pending host request may lose arbitration before it is forced through (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- RN  in  1  reset, asynchronous, active-low.
- p_req  in  1  pipeline access request; one access per cycle while high.
- p_we  in  1  pipeline write enable (1=SW, 0=LW).
- p_addr  in  AW  pipeline word address.
- p_wdata  in  32  pipeline store data.
- p_stall  out  1  combinational; high when p_req=1 and the pipeline is not granted this cycle. The MEM stage holds its inputs while it is high.
- p_rvalid  out  1  registered; pipeline read data valid.
- p_rdata  out  32  pipeline read data.
- h_req  in  1  host request; level signal held with stable h_we/h_addr/h_wdata until h_ack.
- h_we  in  1  host write enable.
- h_addr  in  AW  host word address.
- h_wdata  in  32  host write data.
- h_ack  out  1  one-cycle completion pulse; for reads, h_rdata is valid in the same cycle.
- h_rdata  out  32  host read data.
- h_err  out  1  one-cycle error pulse (see Optional Feature); tied 0 otherwise.
- host_wp  in  1  host write-protect control; ignored unless the feature is enabled.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid the cycle after a read issue.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE; wait_cnt=0; p_rvalid=0; p_rdata=0; h_ack=0; h_rdata=0; h_err=0.
  - An in-flight host access is dropped with no ack.
  - m_en=0 while RN=0.
- FSM states:
  - IDLE: no host access outstanding.
  - H_WAIT: host access issued last cycle; ack due this cycle.
- Grant decision (combinational, every cycle):
  - host_eligible = h_req & (state==IDLE).
  - force = host_eligible & (wait_cnt==MAX_WAIT).
  - Grant host if force, or if host_eligible & !p_req. Otherwise grant pipeline if p_req. Otherwise no access.
  - m_* driven from the granted port; m_en=1 only if a grant exists.
- Transitions:
  - IDLE -> H_WAIT on host grant.
  - H_WAIT -> IDLE unconditionally. In H_WAIT, h_ack=1 and h_rdata=m_rdata for reads; the pipeline may be granted in that same cycle.
  - A host request held high after ack is a new request; it is eligible no earlier than the cycle after ack.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when host_eligible and not granted.
  - Cleared on host grant or when h_req=0.
- Pipeline:
  - Read issued in cycle N gives p_rvalid=1 and p_rdata=m_rdata in N+1.
  - Writes produce no p_rvalid.
  - p_stall=1 exactly in forced-host cycles where p_req=1.
- Simultaneous p_req and h_req with wait_cnt<MAX_WAIT: pipeline wins and wait_cnt increments.
- Write then read of the same address on consecutive cycles returns the new data; the memory is write-first.

Optional Feature:
- Macro IIITB_DMEM_HOST_WP_EN.
- When defined: a host write granted while host_wp=1 is suppressed (m_en=0 that cycle). FSM still enters H_WAIT; next cycle h_ack=1 and h_err=1. The memory is unchanged. Host reads are unaffected.
- When undefined: host_wp is ignored, h_err is constant 0, and all host writes reach memory.

Test Plan:
- Reset: drive RN=0 mid host access -> h_ack never pulses, m_en=0, p_rvalid=0; after release the first host read completes normally.
- Host only: write addr 3 = 0xDEADBEEF, then read addr 3 -> h_ack one cycle after each issue, h_rdata=0xDEADBEEF, p_stall=0.
- Pipeline only: SW addr 7 = 0x12345678 then LW addr 7 back-to-back -> p_stall=0 throughout, p_rvalid=1 one cycle after LW with p_rdata=0x12345678.
- Starvation, MAX_WAIT=4: p_req held high, h_req read addr 1 -> pipeline granted 4 cycles, host forced on cycle 5 with p_stall=1 for exactly that cycle, h_ack on cycle 6, wait_cnt=0.
- Back-to-back host: h_req held high across ack -> issue cycles separated by at least 2; an idle pipeline p_req in each H_WAIT cycle is granted.
- With IIITB_DMEM_HOST_WP_EN and host_wp=1: host write addr 2 = 0x55 -> h_ack=h_err=1, m_en=0 on the issue cycle, and a later read of addr 2 returns the old value.

Source files
------------

// File: rtl/iiitb_dmem_arbiter.sv
// Arbiter sharing the single-port 32x32 data memory between the rv32i MEM stage and a host port.
// The optional host write-protect feature is enabled by defining IIITB_DMEM_HOST_WP_EN.
module iiitb_dmem_arbiter #(
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          RN,
    // pipeline port
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [31:0]   p_wdata,
    output logic          p_stall,
    output logic          p_rvalid,
    output logic [31:0]   p_rdata,
    // host port
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [31:0]   h_wdata,
    output logic          h_ack,
    output logic [31:0]   h_rdata,
    output logic          h_err,
    input  logic          host_wp,
    // memory port
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    // debug visibility of the FSM
    output logic          dbg_state,
    output logic [3:0]    dbg_wait_cnt
);

    // Handshake: the pipeline request is accepted in any cycle where p_req=1 and p_stall=0;
    // a host request is a level held stable until its one-cycle h_ack completion pulse.
    typedef enum logic {IDLE = 1'b0, H_WAIT = 1'b1} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       p_rd_q;
    logic       h_rd_q;
    logic       h_ack_q;
    logic       h_err_q;

    logic host_eligible;
    logic force_host;
    logic grant_h;
    logic grant_p;
    logic h_wr_blocked;

    assign host_eligible = h_req & (state == IDLE);
    assign force_host    = host_eligible & (wait_cnt == WAIT_MAX);
    assign grant_h       = force_host | (host_eligible & ~p_req);
    assign grant_p       = p_req & ~grant_h;

`ifdef IIITB_DMEM_HOST_WP_EN
    // A protected write still walks through H_WAIT so the host sees an ack, with h_err set.
    assign h_wr_blocked = grant_h & h_we & host_wp;
`else
    logic unused_host_wp;
    assign unused_host_wp = host_wp;
    assign h_wr_blocked   = 1'b0;
`endif

    assign p_stall = p_req & ~grant_p;
    assign m_en    = RN & (grant_p | (grant_h & ~h_wr_blocked));
    assign m_we    = m_en & (grant_h ? h_we : p_we);
    assign m_addr  = grant_h ? h_addr : p_addr;
    assign m_wdata = grant_h ? h_wdata : p_wdata;

    // Memory read data is only forwarded to the requester that issued the read last cycle.
    assign p_rvalid = p_rd_q;
    assign p_rdata  = p_rd_q ? m_rdata : 32'h0;
    assign h_ack    = h_ack_q;
    assign h_rdata  = h_rd_q ? m_rdata : 32'h0;
    assign h_err    = h_err_q;

    assign dbg_state    = (state == H_WAIT);
    assign dbg_wait_cnt = wait_cnt;

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            p_rd_q   <= 1'b0;
            h_rd_q   <= 1'b0;
            h_ack_q  <= 1'b0;
            h_err_q  <= 1'b0;
        end else begin
            p_rd_q  <= grant_p & ~p_we;
            h_rd_q  <= grant_h & ~h_we;
            h_ack_q <= grant_h;
            h_err_q <= h_wr_blocked;

            case (state)
                IDLE:    if (grant_h) state <= H_WAIT;
                H_WAIT:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (grant_h || !h_req) begin
                wait_cnt <= 4'd0;
            end else if (host_eligible && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule
